// File: rtl/ysyx_22041211_ifu.sv
// Instruction fetch unit: issues one AXI4-Lite-style read per PC and hands the word to decode.
// Only one read is in flight at a time. A redirect discards the current fetch.
module ysyx_22041211_ifu #(
  parameter int                    ADDR_LEN = 32,
  parameter int                    DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0]   RESET_PC = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_LEN-1:0]  pc_i,
  input  logic                 flush_i,
  output logic [ADDR_LEN-1:0]  araddr_o,
  output logic                 arvalid_o,
  input  logic                 arready_i,
  input  logic [DATA_LEN-1:0]  rdata_i,
  input  logic [1:0]           rresp_i,
  input  logic                 rvalid_i,
  output logic                 rready_o,
  output logic [DATA_LEN-1:0]  inst_o,
  output logic [ADDR_LEN-1:0]  inst_pc_o,
  output logic                 inst_valid_o,
  input  logic                 inst_ready_i,
  output logic                 fetch_err_o,
  output logic                 pc_advance_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_OUT
  } state_t;

  state_t state;
  logic   stale;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      stale        <= 1'b0;
      araddr_o     <= RESET_PC;
      inst_pc_o    <= RESET_PC;
      inst_o       <= '0;
      fetch_err_o  <= 1'b0;
      arvalid_o    <= 1'b0;
      rready_o     <= 1'b0;
      inst_valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A redirect here just delays sampling by one cycle so the new PC is used.
          if (!flush_i) begin
            araddr_o  <= pc_i;
            stale     <= 1'b0;
            arvalid_o <= 1'b1;
            state     <= S_AR;
          end
        end
        S_AR: begin
          // The address phase cannot be withdrawn; a redirect only marks the fetch stale.
          if (flush_i) stale <= 1'b1;
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            state     <= S_R;
          end
        end
        S_R: begin
          if (rvalid_i) begin
            rready_o <= 1'b0;
            if (stale || flush_i) begin
              state <= S_IDLE;
            end else begin
              inst_o       <= rdata_i;
              inst_pc_o    <= araddr_o;
              fetch_err_o  <= (rresp_i != 2'b00);
              inst_valid_o <= 1'b1;
              state        <= S_OUT;
            end
          end else if (flush_i) begin
            stale <= 1'b1;
          end
        end
        S_OUT: begin
          if (flush_i || inst_ready_i) begin
            inst_valid_o <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobe is suppressed during reset so a reset in OUT never advances the PC.
  assign pc_advance_o = (state == S_OUT) & inst_ready_i & ~flush_i & ~rst;

endmodule

// File: tb/tb_ysyx_22041211_ifu.sv
// Directed and randomized bench for ysyx_22041211_ifu; expected timing is derived from
// per-fetch wait counts (each wait cycle adds one cycle to the 4-cycle fetch).
module tb_ysyx_22041211_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        flush_i;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        fetch_err_o;
  logic        pc_advance_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  ysyx_22041211_ifu #(.ADDR_LEN(32), .DATA_LEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .flush_i(flush_i),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .fetch_err_o(fetch_err_o), .pc_advance_o(pc_advance_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One fetch starting in IDLE. mode 0: handed off after d decode stalls;
  // mode 1: flushed in the first OUT cycle; mode 2: reset in the first OUT cycle.
  task automatic fetch(input logic [31:0] pc, input int a, input int r, input int d,
                       input logic [1:0] resp, input logic [31:0] data, input int mode);
    int out_t = 3 + a + r;
    int last  = (mode == 0) ? out_t + d : out_t;
    int n_ar  = 0;
    int n_r   = 0;
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      pc_i         = (t == 0) ? pc : $urandom;
      flush_i      = (mode == 1) && (t == last);
      rst          = (mode == 2) && (t == last);
      arready_i    = (t == 1 + a);
      rvalid_i     = (t == 2 + a + r) || (t == 0 && $urandom_range(0, 1) == 1);
      rdata_i      = (t == 2 + a + r) ? data : $urandom;
      rresp_i      = (t == 2 + a + r) ? resp : 2'($urandom);
      inst_ready_i = (mode != 2) && (t == last);
      #1;
      if (arvalid_o && arready_i) n_ar++;
      if (rready_o && rvalid_i) n_r++;
      chk1("arvalid", arvalid_o, (t >= 1) && (t <= 1 + a));
      chk1("rready", rready_o, (t >= 2 + a) && (t <= 2 + a + r));
      chk1("inst_valid", inst_valid_o, t >= out_t);
      chk1("pc_advance", pc_advance_o, (mode == 0) && (t == last));
      if (t >= 1 && t <= 1 + a) chk32("araddr", araddr_o, pc);
      if (t >= out_t) begin
        chk32("inst", inst_o, data);
        chk32("inst_pc", inst_pc_o, pc);
        chk1("fetch_err", fetch_err_o, resp != 2'b00);
      end
    end
    chk32("ar_handshakes", n_ar, 1);
    chk32("r_handshakes", n_r, 1);
    if (mode == 2) begin
      @(negedge clk);
      rst = 1'b0; flush_i = 1'b1; inst_ready_i = 1'b1; arready_i = 1'b0; rvalid_i = 1'b0;
      #1;
      chk1("rst_inst_valid", inst_valid_o, 1'b0);
      chk1("rst_arvalid", arvalid_o, 1'b0);
      chk1("rst_rready", rready_o, 1'b0);
      chk32("rst_araddr", araddr_o, RESET_PC);
      chk32("rst_inst_pc", inst_pc_o, RESET_PC);
      chk1("rst_pc_advance", pc_advance_o, 1'b0);
    end
  endtask

  // Fetch redirected in AR (where=0) or in R before the response (where=1).
  task automatic fetch_flush(input logic [31:0] pc, input logic [31:0] redirect, input int where);
    for (int t = 0; t <= 3; t++) begin
      @(negedge clk);
      pc_i         = (t == 0) ? pc : redirect;
      flush_i      = (where == 0 && t == 1) || (where == 1 && t == 2);
      arready_i    = (where == 0) ? (t == 2) : (t == 1);
      rvalid_i     = (t == 3);
      rdata_i      = $urandom;
      rresp_i      = 2'($urandom);
      inst_ready_i = 1'($urandom);
      rst          = 1'b0;
      #1;
      chk1("fl_arvalid", arvalid_o, (t == 1) || (where == 0 && t == 2));
      chk1("fl_rready", rready_o, (t == 3) || (where == 1 && t == 2));
      chk1("fl_inst_valid", inst_valid_o, 1'b0);
      chk1("fl_pc_advance", pc_advance_o, 1'b0);
      if (t == 1 || (where == 0 && t == 2)) chk32("fl_araddr", araddr_o, pc);
    end
  endtask

  task automatic idle_flush();
    @(negedge clk);
    flush_i = 1'b1; pc_i = $urandom; rvalid_i = 1'($urandom); arready_i = 1'b0;
    inst_ready_i = 1'($urandom); rst = 1'b0;
    #1;
    chk1("if_arvalid", arvalid_o, 1'b0);
    chk1("if_rready", rready_o, 1'b0);
    chk1("if_inst_valid", inst_valid_o, 1'b0);
    chk1("if_pc_advance", pc_advance_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  logic [31:0] pc;
  int          kind;

  initial begin
    rst = 1'b1; pc_i = '0; flush_i = 1'b0; arready_i = 1'b0; rdata_i = '0;
    rresp_i = 2'b00; rvalid_i = 1'b0; inst_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk32("reset_araddr", araddr_o, RESET_PC);
    chk32("reset_inst_pc", inst_pc_o, RESET_PC);
    chk32("reset_inst", inst_o, 32'h0);
    chk1("reset_fetch_err", fetch_err_o, 1'b0);
    chk1("reset_arvalid", arvalid_o, 1'b0);
    chk1("reset_rready", rready_o, 1'b0);
    chk1("reset_inst_valid", inst_valid_o, 1'b0);
    chk1("reset_pc_advance", pc_advance_o, 1'b0);
    rst = 1'b0; flush_i = 1'b1;

    fetch(32'h8000_0000, 0, 0, 0, 2'b00, 32'h0000_0413, 0);
    fetch(32'h8000_0004, 3, 2, 0, 2'b00, 32'h1234_5678, 0);
    fetch(32'h8000_0008, 0, 0, 4, 2'b00, 32'h0010_0093, 0);
    fetch_flush(32'h8000_000C, 32'h8000_0100, 1);
    fetch(32'h8000_0100, 0, 0, 0, 2'b00, 32'h0000_0013, 0);
    fetch_flush(32'h8000_0104, 32'h8000_0200, 0);
    fetch(32'h8000_0200, 1, 0, 0, 2'b10, 32'hDEAD_BEEF, 0);
    fetch(32'h8000_0204, 0, 1, 1, 2'b00, 32'hCAFE_F00D, 1);
    idle_flush();
    fetch(32'h8000_0300, 0, 0, 0, 2'b00, 32'h0000_0073, 2);
    fetch(32'h8000_0000, 0, 0, 0, 2'b11, 32'h0BAD_0BAD, 0);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 7);
      pc   = $urandom & 32'hFFFF_FFFC;
      if (kind == 0)      fetch_flush(pc, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
      else if (kind == 1) idle_flush();
      else fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 2'($urandom), $urandom, (kind == 2) ? 1 : ((kind == 3) ? 2 : 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ysyx_22041211_ifu.md
# ysyx_22041211_ifu

Instruction fetch unit: the consumer of the fetch address produced by the PC counter. It samples `pc_i` and issues one AXI4-Lite-style read to instruction memory. It returns the fetched word to decode over a valid/ready handshake, then pulses `pc_advance_o` so the PC counter steps. A single in-flight request, a redirect flush and bus error reporting are supported.

## Interface
- `ADDR_LEN`, 32, address width (matches PC counter).
- `DATA_LEN`, 32, instruction word width.
- `RESET_PC`, 32'h8000_0000, reset value of `araddr_o` and `inst_pc_o`.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_i`  in  ADDR_LEN  fetch address from PC counter.
- `flush_i`  in  1  redirect; discards the current fetch.
- `araddr_o`  out  ADDR_LEN  read address, registered.
- `arvalid_o`  out  1  read address valid.
- `arready_i`  in  1  read address accepted.
- `rdata_i`  in  DATA_LEN  read data.
- `rresp_i`  in  2  read response; 2'b00 = OKAY.
- `rvalid_i`  in  1  read data valid.
- `rready_o`  out  1  read data accept.
- `inst_o`  out  DATA_LEN  fetched instruction, registered.
- `inst_pc_o`  out  ADDR_LEN  address of `inst_o`.
- `inst_valid_o`  out  1  instruction valid to decode.
- `inst_ready_i`  in  1  decode accepts.
- `fetch_err_o`  out  1  qualifies `inst_o`; 1 = `rresp_i` was non-OKAY.
- `pc_advance_o`  out  1  one-cycle strobe to the PC counter.

## Operation
- FSM states: IDLE, AR, R, OUT. Sticky bit `stale`.
- IDLE:
  - `arvalid_o`=0, `rready_o`=0, `inst_valid_o`=0.
  - If `flush_i`=0: latch `araddr_o`<=`pc_i`, clear `stale`, go to AR.
  - If `flush_i`=1: stay in IDLE, so the redirected PC is sampled next cycle.
- AR:
  - `arvalid_o`=1; `araddr_o` is held stable.
  - On `arready_i`=1, go to R.
  - `flush_i` here sets `stale`. arvalid is never withdrawn before the handshake completes.
- R:
  - `rready_o`=1.
  - On `rvalid_i`=1 with `stale`=0 and `flush_i`=0: capture `inst_o`<=`rdata_i`, `inst_pc_o`<=`araddr_o`, `fetch_err_o`<=(`rresp_i`!=0), then go to OUT.
  - On `rvalid_i`=1 with `stale`=1 or `flush_i`=1: discard the data, go to IDLE.
  - `flush_i` without `rvalid_i` sets `stale`.
- OUT:
  - `inst_valid_o`=1; `inst_o`, `inst_pc_o` and `fetch_err_o` are held stable.
  - On `inst_ready_i`=1 and `flush_i`=0: go to IDLE.
  - On `flush_i`=1: go to IDLE with no handshake and no advance.
- `pc_advance_o` = (state==OUT) & `inst_ready_i` & ~`flush_i` (combinational).
- A fetch error does not block the flow. It is handed off like a normal instruction, with `fetch_err_o`=1.
- Reset values:
  - state=IDLE, `stale`=0.
  - `araddr_o`=`RESET_PC`, `inst_pc_o`=`RESET_PC`.
  - `inst_o`=0, `fetch_err_o`=0.
  - All valid, ready and strobe outputs 0.
- Reset mid-operation: reset forces IDLE on the next edge regardless of state. The memory slave shares `rst`, so no orphan response is expected. A `rvalid_i` arriving while in IDLE is ignored (`rready_o`=0).

## Timing
- Best case, `arready_i` and `rvalid_i` both high on first assertion:
  - IDLE at cycle 0.
  - `arvalid_o` at cycle 1.
  - `rready_o` at cycle 2.
  - `inst_valid_o` at cycle 3.
  - With `inst_ready_i`=1, `pc_advance_o` pulses at cycle 3.
- Steady-state throughput: one instruction per 4 cycles with zero wait states.
- After a `pc_advance_o` pulse, the PC counter updates on that edge. IDLE samples the new `pc_i` in the following cycle.
- Each wait cycle on `arready_i`, `rvalid_i` or `inst_ready_i` adds exactly one cycle.
- `pc_advance_o` is high for at most one cycle per fetched instruction and never while `flush_i`=1.
- No AR handshake occurs while a response is outstanding. At most one read is in flight.

## Test plan
- Reset, then `pc_i`=0x8000_0000 with zero-wait memory returning 0x0000_0413:
  - `araddr_o`=0x8000_0000 with `arvalid_o` at cycle 1.
  - `inst_o`=0x0000_0413, `inst_pc_o`=0x8000_0000 and `inst_valid_o` at cycle 3.
  - `pc_advance_o` pulses once in cycle 3.
- `arready_i` delayed 3 cycles, `rvalid_i` delayed 2 cycles:
  - `araddr_o` is stable throughout AR.
  - `inst_valid_o` rises at cycle 8.
  - Exactly one AR handshake and one R handshake occur.
- Decode back-pressure, `inst_ready_i`=0 for 4 cycles:
  - `inst_o` and `inst_pc_o` are held.
  - `pc_advance_o` stays 0 until the cycle `inst_ready_i` rises, then pulses once.
- `flush_i` pulse while in R before `rvalid_i`:
  - The response is accepted, then dropped.
  - `inst_valid_o` never rises.
  - The next `araddr_o` equals the redirected `pc_i`, e.g. 0x8000_0100.
- `rresp_i`=2'b10 with `rdata_i`=0xDEAD_BEEF:
  - `inst_valid_o`=1 with `fetch_err_o`=1 and `inst_o`=0xDEAD_BEEF.
  - `pc_advance_o` pulses on the handshake.
- `rst` asserted while in OUT:
  - Next cycle: `inst_valid_o`=0, `araddr_o`=`RESET_PC`, state IDLE.
  - No `pc_advance_o`.
